// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter that muxes the granted master onto one slave port.
// Optional slave-timeout bus-error return is enabled with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int AW = 16,
  parameter int DW = 16
`ifdef WB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A tie in IDLE goes to the master that was not granted last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0) begin
      last_d = 1'b0;
    end else if (state_d == GNT1) begin
      last_d = 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] toCnt_q, toCnt_d;
  logic          abort;

  assign abort = (state_q != IDLE) && (toCnt_q == CW'(TIMEOUT));

  always_comb begin
    toCnt_d = toCnt_q;
    if (abort || (state_d != state_q) || s_ack_i) begin
      toCnt_d = '0;
    end else if (s_cyc_o && s_stb_o) begin
      toCnt_d = toCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_d;
    end
  end
`endif

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    case (state_q)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i & m0_stb_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i & m1_stb_i;
      end
      default: ;
    endcase
`ifdef WB_ARB_TIMEOUT_EN
    // Bus-error return: strobe withdrawn from the slave, master acked with all-ones data.
    if (abort) begin
      s_stb_o = 1'b0;
      if (state_q == GNT0) begin
        m0_ack_o = 1'b1;
        m0_dat_o = '1;
      end else begin
        m1_ack_o = 1'b1;
        m1_dat_o = '1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized and directed bench for wb_arbiter2 against an owner/last-grant reference model.
// Compile with WB_ARB_TIMEOUT_EN defined to also model the timeout bus-error return.
module tb_wb_arbiter2;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0Adr, m1Adr, sAdr;
  logic [DW-1:0] m0DatIn, m1DatIn, m0DatOut, m1DatOut, sDatOut, sDatIn;
  logic          m0We, m0Cyc, m0Stb, m0Ack;
  logic          m1We, m1Cyc, m1Stb, m1Ack;
  logic          sWe, sCyc, sStb, sAck;

  int total = 0;
  int bad = 0;

  // Reference model: who owns the bus (-1 none), who was granted last, stalled-cycle count.
  int mOwner = -1;
  int mLast = 1;
  int mCnt = 0;
  logic eCyc, eStb;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0Adr), .m0_dat_i(m0DatIn), .m0_we_i(m0We), .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb),
    .m0_dat_o(m0DatOut), .m0_ack_o(m0Ack),
    .m1_adr_i(m1Adr), .m1_dat_i(m1DatIn), .m1_we_i(m1We), .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb),
    .m1_dat_o(m1DatOut), .m1_ack_o(m1Ack),
    .s_adr_o(sAdr), .s_dat_o(sDatOut), .s_we_o(sWe), .s_cyc_o(sCyc), .s_stb_o(sStb),
    .s_dat_i(sDatIn), .s_ack_i(sAck)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output against what the model says the bus should look like now.
  task automatic checkAgainstModel();
    logic [AW-1:0] eAdr;
    logic [DW-1:0] eSdat, eDat0, eDat1;
    logic          eWe, eAck0, eAck1;
    eAdr = '0; eSdat = '0; eWe = 1'b0; eCyc = 1'b0; eStb = 1'b0;
    eAck0 = 1'b0; eAck1 = 1'b0; eDat0 = sDatIn; eDat1 = sDatIn;
    if (mOwner == 0) begin
      eAdr = m0Adr; eSdat = m0DatIn; eWe = m0We; eCyc = m0Cyc; eStb = m0Stb;
      eAck0 = sAck & m0Stb;
    end else if (mOwner == 1) begin
      eAdr = m1Adr; eSdat = m1DatIn; eWe = m1We; eCyc = m1Cyc; eStb = m1Stb;
      eAck1 = sAck & m1Stb;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (mOwner >= 0 && mCnt == TIMEOUT) begin
      eStb = 1'b0;
      if (mOwner == 0) begin
        eAck0 = 1'b1; eDat0 = '1;
      end else begin
        eAck1 = 1'b1; eDat1 = '1;
      end
    end
`endif
    checkOutput("s_adr", 32'(sAdr), 32'(eAdr));
    checkOutput("s_dat", 32'(sDatOut), 32'(eSdat));
    checkOutput("s_we", 32'(sWe), 32'(eWe));
    checkOutput("s_cyc", 32'(sCyc), 32'(eCyc));
    checkOutput("s_stb", 32'(sStb), 32'(eStb));
    checkOutput("m0_ack", 32'(m0Ack), 32'(eAck0));
    checkOutput("m1_ack", 32'(m1Ack), 32'(eAck1));
    checkOutput("m0_dat", 32'(m0DatOut), 32'(eDat0));
    checkOutput("m1_dat", 32'(m1DatOut), 32'(eDat1));
  endtask

  task automatic applyStimulus(input logic r,
                               input logic c0, input logic s0, input logic w0,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic c1, input logic s1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic ack, input logic [DW-1:0] sdat);
    rst = r;
    m0Cyc = c0; m0Stb = s0; m0We = w0; m0Adr = a0; m0DatIn = d0;
    m1Cyc = c1; m1Stb = s1; m1We = w1; m1Adr = a1; m1DatIn = d1;
    sAck = ack; sDatIn = sdat;
    @(negedge clk);
    checkAgainstModel();
  endtask

  // Advance one clock and move the model with the inputs that were present at the edge.
  task automatic stepClock();
    int nOwner;
    @(posedge clk);
    if (rst) begin
      mOwner = -1; mLast = 1; mCnt = 0;
    end else begin
      nOwner = mOwner;
      if (mOwner < 0) begin
        if (m0Cyc && m1Cyc) nOwner = 1 - mLast;
        else if (m0Cyc)     nOwner = 0;
        else if (m1Cyc)     nOwner = 1;
      end else if (!((mOwner == 0) ? m0Cyc : m1Cyc)) begin
        nOwner = (((mOwner == 0) ? m1Cyc : m0Cyc)) ? 1 - mOwner : -1;
      end
      if ((mOwner >= 0 && mCnt == TIMEOUT) || nOwner != mOwner || sAck) mCnt = 0;
      else if (eCyc && eStb) mCnt++;
      if (nOwner >= 0) mLast = nOwner;
      mOwner = nOwner;
    end
    #1;
  endtask

  task automatic resetCycle();
    applyStimulus(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, '0);
    stepClock();
  endtask

  initial begin
    int ackSeen;
    logic c0r, c1r;
    rst = 1'b1;
    m0Cyc = 0; m0Stb = 0; m0We = 0; m0Adr = '0; m0DatIn = '0;
    m1Cyc = 0; m1Stb = 0; m1We = 0; m1Adr = '0; m1DatIn = '0;
    sAck = 0; sDatIn = '0;
    @(posedge clk);
    #1;
    mOwner = -1; mLast = 1; mCnt = 0;

    // Reset state: idle bus.
    applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 1, 16'hBEEF);
    checkOutput("reset_s_cyc", 32'(sCyc), 32'd0);
    stepClock();

    // m0 single read, slave acks one cycle after the strobe reaches it.
    applyStimulus(0, 1, 1, 0, 16'h0100, '0, 0, 0, 0, '0, '0, 0, '0);
    checkOutput("t1_cyc_latency", 32'(sCyc), 32'd0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'h0100, '0, 0, 0, 0, '0, '0, 0, '0);
    checkOutput("t1_cyc_granted", 32'(sCyc), 32'd1);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'h0100, '0, 0, 0, 0, '0, '0, 1, 16'h1234);
    checkOutput("t1_m0_ack", 32'(m0Ack), 32'd1);
    checkOutput("t1_m0_dat", 32'(m0DatOut), 32'h1234);
    checkOutput("t1_m1_ack", 32'(m1Ack), 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, '0);
    stepClock();

    // Tie after reset goes to m0, direct handover to m1, then next tie to m0 again.
    resetCycle();
    applyStimulus(0, 1, 1, 0, 16'hA000, '0, 1, 1, 1, 16'hB000, '0, 0, '0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'hA000, '0, 1, 1, 1, 16'hB000, '0, 1, '0);
    checkOutput("t2_first_tie_m0", 32'(sAdr), 32'hA000);
    stepClock();
    applyStimulus(0, 0, 0, 0, 16'hA000, '0, 1, 1, 1, 16'hB000, '0, 0, '0);
    checkOutput("t2_handover_no_overlap", 32'(sCyc), 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 16'hA000, '0, 1, 1, 1, 16'hB000, '0, 0, '0);
    checkOutput("t2_handover_m1", 32'(sAdr), 32'hB000);
    checkOutput("t2_handover_cyc", 32'(sCyc), 32'd1);
    stepClock();
    applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, '0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'hA004, '0, 1, 1, 0, 16'hB004, '0, 0, '0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'hA004, '0, 1, 1, 0, 16'hB004, '0, 0, '0);
    checkOutput("t2_second_tie_m0", 32'(sAdr), 32'hA004);
    stepClock();
    applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, '0);
    stepClock();

    // m1 four-beat burst; m0 must wait until m1 releases cyc.
    resetCycle();
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 1, 16'hC000, 16'h5555, 0, '0);
    stepClock();
    for (int beat = 0; beat < 4; beat++) begin
      applyStimulus(0, 1, 1, 0, 16'hD000, '0, 1, 1, 1, 16'(16'hC000 + beat), 16'h5555, 1, '0);
      checkOutput("t3_burst_adr", 32'(sAdr), 32'(16'hC000 + beat));
      checkOutput("t3_m0_waits", 32'(m0Ack), 32'd0);
      stepClock();
    end
    applyStimulus(0, 1, 1, 0, 16'hD000, '0, 0, 0, 0, '0, '0, 0, '0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'hD000, '0, 0, 0, 0, '0, '0, 1, 16'h0042);
    checkOutput("t3_m0_after_burst", 32'(sAdr), 32'hD000);
    stepClock();

    // Reset during GNT0 with strobe and ack present; afterwards a tie must favour m0.
    applyStimulus(1, 1, 1, 0, 16'hD000, '0, 0, 0, 0, '0, '0, 1, 16'h0042);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'hD000, '0, 1, 1, 0, 16'hE000, '0, 1, 16'h0042);
    checkOutput("t4_reset_s_cyc", 32'(sCyc), 32'd0);
    checkOutput("t4_reset_m0_ack", 32'(m0Ack), 32'd0);
    stepClock();
    applyStimulus(0, 1, 1, 0, 16'hD000, '0, 1, 1, 0, 16'hE000, '0, 0, '0);
    checkOutput("t4_last_is_1", 32'(sAdr), 32'hD000);
    stepClock();

    // Stray slave acks: no grant, and granted master without strobe.
    resetCycle();
    applyStimulus(0, 0, 1, 0, '0, '0, 0, 1, 0, '0, '0, 1, '0);
    checkOutput("t5_idle_ack0", 32'(m0Ack), 32'd0);
    checkOutput("t5_idle_ack1", 32'(m1Ack), 32'd0);
    stepClock();
    applyStimulus(0, 1, 0, 0, 16'h0010, '0, 0, 0, 0, '0, '0, 0, '0);
    stepClock();
    applyStimulus(0, 1, 0, 0, 16'h0010, '0, 0, 1, 0, '0, '0, 1, '0);
    checkOutput("t5_nostb_ack0", 32'(m0Ack), 32'd0);
    checkOutput("t5_nongranted_ack1", 32'(m1Ack), 32'd0);
    stepClock();

    // Slave never acks m0: stalled forever unless the timeout is built in.
    resetCycle();
    ackSeen = 0;
    for (int i = 0; i < 21; i++) begin
      applyStimulus(0, 1, 1, 0, 16'h0F00, '0, 0, 0, 0, '0, '0, 0, 16'h0000);
      if (m0Ack) ackSeen++;
      stepClock();
    end
`ifdef WB_ARB_TIMEOUT_EN
    checkOutput("t6_timeout_acks", 32'(ackSeen), 32'd1);
`else
    checkOutput("t6_stalled_acks", 32'(ackSeen), 32'd0);
`endif

    // Randomized traffic with occasional resets.
    resetCycle();
    c0r = 1'b0;
    c1r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) c0r = ~c0r;
      if ($urandom_range(5) == 0) c1r = ~c1r;
      applyStimulus(logic'($urandom_range(99) == 0),
                    c0r, logic'($urandom_range(3) != 0), logic'($urandom_range(1)),
                    AW'($urandom), DW'($urandom),
                    c1r, logic'($urandom_range(3) != 0), logic'($urandom_range(1)),
                    AW'($urandom), DW'($urandom),
                    logic'($urandom_range(2) == 0), DW'($urandom));
      stepClock();
    end

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
